// File: rtl/clk_gen_multi_if.sv
// Control and waveform bundle for the multi-channel clock generator.
// The controller (master) programs lengths/enables; the generator (slave) returns waveforms and strobes.
interface clk_gen_multi_if #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
);
   logic [CH-1:0]       enable;
   logic [CH-1:0]       start_value;
   logic [CH*CNT_W-1:0] high_len;
   logic [CH*CNT_W-1:0] low_len;
   logic                sync;
   logic [CH-1:0]       clk_out;
   logic [CH-1:0]       rise_pulse;
   logic [CH-1:0]       fall_pulse;

   modport master (
      output enable, start_value, high_len, low_len, sync,
      input  clk_out, rise_pulse, fall_pulse
   );

   modport slave (
      input  enable, start_value, high_len, low_len, sync,
      output clk_out, rise_pulse, fall_pulse
   );
endinterface

// File: rtl/clk_gen_multi.sv
// CH independent programmable divided-clock generators with a shared phase-align sync.
// Each channel is an IDLE/HIGH/LOW FSM with its own down-counter and latched lengths.
module clk_gen_chan #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             start_value,
   input  logic             sync,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   output logic             clk_out,
   output logic             rise_pulse,
   output logic             fall_pulse
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d;
   logic             out_d, rise_d, fall_d;

   // A zero length behaves as one cycle, so the reload value is max(len,1)-1.
   function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - ONE;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         clk_out    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         clk_out    <= out_d;
         rise_pulse <= rise_d;
         fall_pulse <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      out_d   = clk_out;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         out_d   = 1'b0;
         fall_d  = clk_out;
      end else if (state_q == IDLE || sync) begin
         // Fresh start and sync restart are the same operation; strobes follow the level change.
         hi_d = high_len;
         lo_d = low_len;
         if (start_value) begin
            state_d = HIGH;
            cnt_d   = reload(high_len);
            out_d   = 1'b1;
            rise_d  = !clk_out;
         end else begin
            state_d = LOW;
            cnt_d   = reload(low_len);
            out_d   = 1'b0;
            fall_d  = clk_out;
         end
      end else begin
         case (state_q)
            HIGH: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  state_d = LOW;
                  cnt_d   = reload(lo_q);
                  out_d   = 1'b0;
                  fall_d  = 1'b1;
               end
            end
            LOW: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  // New lengths are only picked up at a period boundary.
                  hi_d    = high_len;
                  lo_d    = low_len;
                  state_d = HIGH;
                  cnt_d   = reload(high_len);
                  out_d   = 1'b1;
                  rise_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
endmodule

module clk_gen_multi #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
) (
   input logic            clk,
   input logic            rst_n,
   clk_gen_multi_if.slave bus
);
   logic [CH-1:0] out_w, rise_w, fall_w;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      clk_gen_chan #(.CNT_W(CNT_W)) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .enable      (bus.enable[i]),
         .start_value (bus.start_value[i]),
         .sync        (bus.sync),
         .high_len    (bus.high_len[i*CNT_W +: CNT_W]),
         .low_len     (bus.low_len[i*CNT_W +: CNT_W]),
         .clk_out     (out_w[i]),
         .rise_pulse  (rise_w[i]),
         .fall_pulse  (fall_w[i])
      );
   end

   assign bus.clk_out    = out_w;
   assign bus.rise_pulse = rise_w;
   assign bus.fall_pulse = fall_w;
endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi: start, min lengths, length change, sync, disable, async reset.
module tb_clk_gen_multi;
   localparam int CH    = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   clk_gen_multi_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

   clk_gen_multi #(.CH(CH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are observed at the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_ch(input int ch, input logic sv, input int hi, input int lo);
      bus.start_value[ch]              = sv;
      bus.high_len[ch*CNT_W +: CNT_W]  = CNT_W'(hi);
      bus.low_len[ch*CNT_W +: CNT_W]   = CNT_W'(lo);
   endtask

   task automatic idle_all();
      bus.enable = '0;
      bus.sync   = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({bus.clk_out, bus.rise_pulse, bus.fall_pulse} !== 12'h000)
         $display("FAIL reset_state: got %b required 0", {bus.clk_out, bus.rise_pulse, bus.fall_pulse});
      else passed++;
   endtask

   task automatic test_basic();
      logic [2:0] exp;
      set_ch(0, 1'b1, 3, 2);
      bus.enable[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         exp = {(k % 5) < 3, (k % 5) == 0, (k % 5) == 3};
         total++;
         if ({bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0]} !== exp)
            $display("FAIL basic_3_2 k=%0d: got %b required %b", k,
                     {bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0]}, exp);
         else passed++;
      end
      idle_all();
   endtask

   task automatic test_min_len();
      logic [2:0] exp;
      set_ch(1, 1'b1, 0, 0);
      bus.enable[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         exp = {(k % 2) == 0, (k % 2) == 0, (k % 2) == 1};
         total++;
         if ({bus.clk_out[1], bus.rise_pulse[1], bus.fall_pulse[1]} !== exp)
            $display("FAIL min_len k=%0d: got %b required %b", k,
                     {bus.clk_out[1], bus.rise_pulse[1], bus.fall_pulse[1]}, exp);
         else passed++;
      end
      idle_all();
   endtask

   task automatic test_len_change();
      logic [13:0] exp_o, exp_r, exp_f;
      exp_o = 14'b10000100001111;
      exp_r = 14'b10000100000001;
      exp_f = 14'b00001000010000;
      set_ch(2, 1'b1, 4, 4);
      bus.enable[2] = 1'b1;
      for (int k = 0; k < 14; k++) begin
         tick();
         total++;
         if ({bus.clk_out[2], bus.rise_pulse[2], bus.fall_pulse[2]} !== {exp_o[k], exp_r[k], exp_f[k]})
            $display("FAIL len_change k=%0d: got %b required %b", k,
                     {bus.clk_out[2], bus.rise_pulse[2], bus.fall_pulse[2]}, {exp_o[k], exp_r[k], exp_f[k]});
         else passed++;
         if (k == 1) bus.high_len[2*CNT_W +: CNT_W] = 8'd1;
      end
      idle_all();
   endtask

   task automatic test_sync();
      logic [2:0] e0, e3;
      set_ch(0, 1'b1, 3, 2);
      set_ch(3, 1'b0, 5, 5);
      bus.enable[0] = 1'b1;
      tick();
      tick();
      bus.enable[3] = 1'b1;
      tick();
      tick();
      total++;
      if ({bus.clk_out[0], bus.clk_out[3]} !== 2'b00)
         $display("FAIL sync_pre: got %b required 00", {bus.clk_out[0], bus.clk_out[3]});
      else passed++;
      bus.sync = 1'b1;
      tick();
      bus.sync = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         e0 = {(k % 5) < 3, (k % 5) == 0, (k % 5) == 3};
         e3 = (k == 5) ? 3'b110 : 3'b000;
         total++;
         if ({bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0],
              bus.clk_out[3], bus.rise_pulse[3], bus.fall_pulse[3], bus.clk_out[2:1]} !== {e0, e3, 2'b00})
            $display("FAIL sync_low k=%0d: got %b required %b", k,
                     {bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0],
                      bus.clk_out[3], bus.rise_pulse[3], bus.fall_pulse[3], bus.clk_out[2:1]}, {e0, e3, 2'b00});
         else passed++;
      end
      // Both channels high now: ch0 restarts high silently, ch3 restarts low with a fall strobe.
      bus.sync = 1'b1;
      tick();
      bus.sync = 1'b0;
      total++;
      if ({bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0],
           bus.clk_out[3], bus.rise_pulse[3], bus.fall_pulse[3]} !== 6'b100_001)
         $display("FAIL sync_high: got %b required 100001",
                  {bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0],
                   bus.clk_out[3], bus.rise_pulse[3], bus.fall_pulse[3]});
      else passed++;
      tick();
      total++;
      if ({bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0],
           bus.clk_out[3], bus.rise_pulse[3], bus.fall_pulse[3]} !== 6'b100_000)
         $display("FAIL sync_after: got %b required 100000",
                  {bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0],
                   bus.clk_out[3], bus.rise_pulse[3], bus.fall_pulse[3]});
      else passed++;
      idle_all();
   endtask

   task automatic test_disable();
      logic [14:0] exp;
      logic [14:0] got;
      set_ch(0, 1'b1, 3, 2);
      bus.enable[0] = 1'b1;
      tick();
      tick();
      bus.enable[0] = 1'b0;
      tick();
      got[14:12] = {bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0]};
      tick();
      got[11:9] = {bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0]};
      bus.start_value[0] = 1'b0;
      bus.enable[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         got[8-3*k -: 3] = {bus.clk_out[0], bus.rise_pulse[0], bus.fall_pulse[0]};
      end
      exp = 15'b001_000_000_000_110;
      total++;
      if (got !== exp)
         $display("FAIL disable_reenable: got %b required %b", got, exp);
      else passed++;
      idle_all();
   endtask

   task automatic test_async_reset();
      set_ch(0, 1'b1, 3, 2);
      set_ch(1, 1'b1, 0, 0);
      set_ch(2, 1'b1, 4, 4);
      set_ch(3, 1'b1, 5, 5);
      bus.enable = '1;
      tick();
      total++;
      if (bus.clk_out !== 4'b1111)
         $display("FAIL all_start: got %b required 1111", bus.clk_out);
      else passed++;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.clk_out, bus.rise_pulse, bus.fall_pulse} !== 12'h000)
         $display("FAIL async_reset: got %b required 0", {bus.clk_out, bus.rise_pulse, bus.fall_pulse});
      else passed++;
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if ({bus.clk_out, bus.rise_pulse, bus.fall_pulse} !== {4'b1111, 4'b1111, 4'b0000})
         $display("FAIL restart_after_reset: got %b required 111111110000",
                  {bus.clk_out, bus.rise_pulse, bus.fall_pulse});
      else passed++;
      idle_all();
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.enable      = '0;
      bus.start_value = '0;
      bus.high_len    = '0;
      bus.low_len     = '0;
      bus.sync        = 1'b0;
      test_reset();
      tick();
      rst_n = 1'b1;
      tick();
      test_basic();
      test_min_len();
      test_len_change();
      test_sync();
      test_disable();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
